spm_operand_loader: RTL
=======================

SPM_OPERAND_LOADER -- requirements
Module: spm_operand_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of (x,y) operand pairs buffered; legal values are 2 or 4.
REQ-002 SHALL have parameter MAX_WAIT, default 24, meaning the number of cycles in WAIT_DONE before a timeout.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 8 bits: byte stream; even-numbered bytes are x, odd-numbered bytes are y.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: a byte is accepted on an edge where in_valid and in_ready are both 1.
REQ-008 SHALL have port mul_x, output, 8 bits: multiplicand driven to the serial multiplier.
REQ-009 SHALL have port mul_y, output, 8 bits: multiplier operand driven to the serial multiplier.
REQ-010 SHALL have port mul_start, output, 1 bit: one-cycle active-high pulse that loads and restarts the multiplier.
REQ-011 SHALL have port mul_done, input, 1 bit: completion level from the multiplier; held high until the next mul_start.
REQ-012 SHALL have port busy, output, 1 bit: high in states START and WAIT_DONE.
REQ-013 SHALL have port op_done, output, 1 bit: one-cycle pulse when an operation completes.
REQ-014 SHALL have port timeout, output, 1 bit: one-cycle pulse when an operation is abandoned.
REQ-015 SHALL have port fifo_count, output, 3 bits: current number of pairs held in the FIFO.

Function
REQ-016 SHALL keep a phase bit: phase=0 means the next accepted byte is latched into x_hold and phase becomes 1.
REQ-017 SHALL, when phase=1, push {x_hold, byte} into the FIFO on acceptance and clear phase to 0.
REQ-018 SHALL drive in_ready = (phase==0) OR (fifo_count < FIFO_DEPTH), using registered state only; a pop in the same cycle does not raise in_ready.
REQ-019 SHALL make the FIFO a circular buffer whose pointers wrap modulo FIFO_DEPTH.
REQ-020 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and keep the data intact.
REQ-021 SHALL implement the FSM state IDLE: if fifo_count>0, go to START on the next edge.
REQ-022 SHALL implement the FSM state START (one cycle): load mul_x/mul_y from the FIFO head, assert mul_start, pop the FIFO, then go to WAIT_DONE.
REQ-023 SHALL implement the FSM state WAIT_DONE: accept completion only after mul_done has been sampled 0 at least once since START (low_seen flag); a stale high level is ignored.
REQ-024 SHALL, in WAIT_DONE with low_seen=1 and mul_done=1, pulse op_done for one cycle and go to IDLE.
REQ-025 SHALL, when the wait counter reaches MAX_WAIT-1 without completion, pulse timeout for one cycle and go to IDLE; if completion and timeout occur in the same cycle, completion wins.
REQ-026 SHALL hold mul_x and mul_y stable from START until the next START.
REQ-027 SHALL make latency = 2 edges from y acceptance to the mul_start cycle when IDLE with an empty FIFO.
REQ-028 SHALL pop at most one pair per operation and never pop while fifo_count=0.

Reset
REQ-029 SHALL, on rst=0 at any time including mid-operation, immediately force: state IDLE, phase 0, FIFO empty, fifo_count 0, mul_x 0, mul_y 0, mul_start 0, op_done 0, timeout 0, low_seen 0, wait counter 0.
REQ-030 SHALL drive in_ready=1 while in reset; no byte is accepted while rst=0.
REQ-031 SHALL resume normal operation on the first rising edge after rst returns high.

Verification
REQ-032 SHALL cover single op: bytes 0x03,0x05 -> mul_x=0x03, mul_y=0x05, mul_start 2 edges after y; mul_done rises -> op_done pulse; busy low after.
REQ-033 SHALL cover back-to-back: 6 bytes (0x02,0x04,0x07,0x09,0xFF,0xFF) with FIFO_DEPTH=2 and a slow multiplier -> fifo_count peaks at 2, in_ready low only when phase=1, three starts in order, no loss or reorder.
REQ-034 SHALL cover stale done: mul_done held 1 through START and for 3 cycles -> no op_done until mul_done goes 0 then 1.
REQ-035 SHALL cover timeout: mul_done never rises -> timeout pulse exactly MAX_WAIT cycles after entering WAIT_DONE; the next queued pair then starts.
REQ-036 SHALL cover reset mid-op: rst low during WAIT_DONE with one pair queued and phase=1 -> all outputs zeroed, fifo_count 0, next byte treated as x.
REQ-037 SHALL cover wrap-around: 10 pairs streamed through FIFO_DEPTH=2 -> all products requested in input order.

Source files
------------

// File: rtl/spm_operand_loader_if.sv
// Byte stream in, operand pair plus start/done handshake out to the serial multiplier.
interface spm_operand_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] mul_x;
   logic [7:0] mul_y;
   logic       mul_start;
   logic       mul_done;

   modport slave (
      input  in_data, in_valid, mul_done,
      output in_ready, mul_x, mul_y, mul_start
   );

   modport master (
      output in_data, in_valid, mul_done,
      input  in_ready, mul_x, mul_y, mul_start
   );
endinterface

// File: rtl/spm_operand_loader.sv
// Pairs an x/y byte stream into a small FIFO and feeds one pair at a time to a
// serial multiplier, waiting for a fresh done level or timing out.
module spm_operand_loader #(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   spm_operand_loader_if.slave  bus,
   output logic                 busy,
   output logic                 op_done,
   output logic                 timeout,
   output logic [2:0]           fifo_count
);
   localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

   state_t                          state_q, state_d;
   logic                            phase_q, phase_d;
   logic [7:0]                      x_hold_q, x_hold_d;
   logic [FIFO_DEPTH-1:0][15:0]     mem_q, mem_d;
   logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]                      count_q, count_d;
   logic [7:0]                      mul_x_q, mul_x_d, mul_y_q, mul_y_d;
   logic                            mul_start_q, mul_start_d;
   logic                            op_done_q, op_done_d;
   logic                            timeout_q, timeout_d;
   logic                            low_seen_q, low_seen_d;
   logic [WW-1:0]                   wait_q, wait_d;
   logic                            accept, push, pop;

   // Ready looks only at registered state so a same-cycle pop never widens it.
   assign bus.in_ready  = !phase_q || (count_q < 3'(FIFO_DEPTH));
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = accept && phase_q;

   assign bus.mul_x     = mul_x_q;
   assign bus.mul_y     = mul_y_q;
   assign bus.mul_start = mul_start_q;
   assign busy          = (state_q != IDLE);
   assign op_done       = op_done_q;
   assign timeout       = timeout_q;
   assign fifo_count    = count_q;

   always_comb begin
      phase_d  = accept ? !phase_q : phase_q;
      x_hold_d = (accept && !phase_q) ? bus.in_data : x_hold_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = {x_hold_q, bus.in_data};
         wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      rd_ptr_d = rd_ptr_q;
      if (pop)
         rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mul_x_d     = mul_x_q;
      mul_y_d     = mul_y_q;
      mul_start_d = 1'b0;
      op_done_d   = 1'b0;
      timeout_d   = 1'b0;
      low_seen_d  = low_seen_q;
      wait_d      = wait_q;
      pop         = 1'b0;
      case (state_q)
         IDLE: if (count_q != 3'd0) state_d = START;
         START: begin
            if (count_q != 3'd0) begin
               pop         = 1'b1;
               mul_x_d     = mem_q[rd_ptr_q][15:8];
               mul_y_d     = mem_q[rd_ptr_q][7:0];
               mul_start_d = 1'b1;
            end
            low_seen_d = 1'b0;
            wait_d     = '0;
            state_d    = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!bus.mul_done) low_seen_d = 1'b1;
            // A done level still high from the previous op must not count.
            if (low_seen_q && bus.mul_done) begin
               op_done_d = 1'b1;
               state_d   = IDLE;
            end else if (wait_q == WW'(MAX_WAIT - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         phase_q     <= 1'b0;
         x_hold_q    <= '0;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mul_x_q     <= '0;
         mul_y_q     <= '0;
         mul_start_q <= 1'b0;
         op_done_q   <= 1'b0;
         timeout_q   <= 1'b0;
         low_seen_q  <= 1'b0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         x_hold_q    <= x_hold_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mul_x_q     <= mul_x_d;
         mul_y_q     <= mul_y_d;
         mul_start_q <= mul_start_d;
         op_done_q   <= op_done_d;
         timeout_q   <= timeout_d;
         low_seen_q  <= low_seen_d;
         wait_q      <= wait_d;
      end
   end
endmodule
